tri_port_tx: RTL and testbench

- Transmit-side driver for the three-port 8-bit data/valid interface (port1..port3 data + valid, single clock).
- Accepts tagged bytes from one upstream write channel and buffers them in per-port FIFOs.
- Emits buffered bytes on each port's data/valid pair with a programmable idle gap between beats.
- Sits upstream of the three-port receiver and feeds it stimulus in the combinational test environment.

---
 rtl/tri_port_tx_pkg.sv | 20 ++
 rtl/tri_port_tx_if.sv | 18 +
 rtl/tri_port_tx_lane.sv | 106 ++++++++++
 rtl/tri_port_tx.sv | 87 ++++++++
 tb/tb_tri_port_tx.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tri_port_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : tri_port_tx_pkg
//  Brief    : Shared types and constants for the three-port transmit driver.
//  Revision : 1.0
// ============================================================================
package tri_port_tx_pkg;
    localparam int NUM_PORTS = 3;
    localparam int DATA_W    = 8;

    typedef logic [1:0] port_id_t;
    localparam port_id_t PORT_ILLEGAL = 2'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } lane_state_t;
endpackage
`default_nettype wire

// File: rtl/tri_port_tx_if.sv
`default_nettype none
// ============================================================================
//  Module   : tri_port_tx_if
//  Brief    : Upstream tagged-byte write channel (valid/ready).
//  Revision : 1.0
// ============================================================================
interface tri_port_tx_if;
    import tri_port_tx_pkg::*;

    logic                wr_valid;
    logic                wr_ready;
    port_id_t            wr_port;
    logic [DATA_W-1:0]   wr_data;

    modport master (output wr_valid, wr_port, wr_data, input wr_ready);
    modport slave  (input wr_valid, wr_port, wr_data, output wr_ready);
endinterface
`default_nettype wire

// File: rtl/tri_port_tx_lane.sv
`default_nettype none
// ============================================================================
//  Module   : tx_port_lane
//  Brief    : One output lane: byte FIFO, beat/gap FSM and output register.
//  Revision : 1.0
// ============================================================================
module tx_port_lane
    import tri_port_tx_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int GAP   = 0,
    parameter int GAP_W = 4
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              push,
    input  wire logic [DATA_W-1:0] push_data,
    input  wire logic              tx_en,
    output logic                   full,
    output logic                   empty,
    output logic [DATA_W-1:0]      out_data,
    output logic                   out_valid
);
    localparam int               AW    = $clog2(DEPTH);
    localparam logic [GAP_W-1:0] C_GAP = GAP_W'(GAP);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW:0]       r_wr_ptr;
    logic [AW:0]       r_rd_ptr;
    lane_state_t       r_state;
    logic [GAP_W-1:0]  r_gap_cnt;
    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic              w_can_pop;
    logic              w_pop;

    assign empty     = (r_wr_ptr == r_rd_ptr);
    assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_can_pop = tx_en && !empty;
    assign out_data  = r_data;
    assign out_valid = r_valid;

    // The last gap cycle doubles as the idle decision so exactly GAP
    // empty cycles separate beats.
    always_comb begin
        w_pop = 1'b0;
        case (r_state)
            ST_IDLE: w_pop = w_can_pop;
            ST_SEND: w_pop = (GAP == 0) && w_can_pop;
            ST_GAP:  w_pop = (r_gap_cnt == GAP_W'(1)) && w_can_pop;
            default: w_pop = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push && !full) begin
            r_mem[r_wr_ptr[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_state   <= ST_IDLE;
            r_gap_cnt <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
        end else begin
            if (push && !full) begin
                r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
                r_data   <= r_mem[r_rd_ptr[AW-1:0]];
            end
            r_valid <= w_pop;
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) r_state <= ST_SEND;
                end
                ST_SEND: begin
                    if (w_pop) begin
                        r_state <= ST_SEND;
                    end else if (GAP > 0) begin
                        r_state   <= ST_GAP;
                        r_gap_cnt <= C_GAP;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_GAP: begin
                    r_gap_cnt <= r_gap_cnt - GAP_W'(1);
                    if (w_pop) begin
                        r_state <= ST_SEND;
                    end else if (r_gap_cnt == GAP_W'(1)) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: rtl/tri_port_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tri_port_tx
//  Brief    : Three-port 8-bit transmit driver fed by one tagged write channel.
//  Revision : 1.0
// ============================================================================
module tri_port_tx
    import tri_port_tx_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int GAP   = 0,
    parameter int GAP_W = 4
) (
    input  wire logic                 clk,
    input  wire logic                 rst_n,
    tri_port_tx_if.slave              wr,
    input  wire logic [NUM_PORTS-1:0] tx_en,
    input  wire logic                 clr_err,
    output logic [DATA_W-1:0]         port1_data,
    output logic                      port1_valid,
    output logic [DATA_W-1:0]         port2_data,
    output logic                      port2_valid,
    output logic [DATA_W-1:0]         port3_data,
    output logic                      port3_valid,
    output logic [NUM_PORTS-1:0]      fifo_full,
    output logic [NUM_PORTS-1:0]      fifo_empty,
    output logic                      drop_err
);
    logic                 w_ready;
    logic                 w_accept;
    logic                 w_illegal;
    logic [NUM_PORTS-1:0] w_push;
    logic [DATA_W-1:0]    w_lane_data [NUM_PORTS];
    logic [NUM_PORTS-1:0] w_lane_valid;
    logic                 r_drop_err;

    // Illegal destinations are always accepted so the source never stalls on them.
    always_comb begin
        w_ready = 1'b1;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (wr.wr_port == port_id_t'(i + 1)) w_ready = !fifo_full[i];
        end
    end

    assign wr.wr_ready = w_ready;
    assign w_accept    = wr.wr_valid && w_ready;
    assign w_illegal   = w_accept && (wr.wr_port == PORT_ILLEGAL);

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_lane
        assign w_push[i] = w_accept && (wr.wr_port == port_id_t'(i + 1));

        tx_port_lane #(
            .DEPTH (DEPTH),
            .GAP   (GAP),
            .GAP_W (GAP_W)
        ) u_lane (
            .clk       (clk),
            .rst_n     (rst_n),
            .push      (w_push[i]),
            .push_data (wr.wr_data),
            .tx_en     (tx_en[i]),
            .full      (fifo_full[i]),
            .empty     (fifo_empty[i]),
            .out_data  (w_lane_data[i]),
            .out_valid (w_lane_valid[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop_err <= 1'b0;
        end else if (w_illegal) begin
            r_drop_err <= 1'b1;
        end else if (clr_err) begin
            r_drop_err <= 1'b0;
        end
    end

    assign drop_err    = r_drop_err;
    assign port1_data  = w_lane_data[0];
    assign port1_valid = w_lane_valid[0];
    assign port2_data  = w_lane_data[1];
    assign port2_valid = w_lane_valid[1];
    assign port3_data  = w_lane_data[2];
    assign port3_valid = w_lane_valid[2];
endmodule
`default_nettype wire

// File: tb/tb_tri_port_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tri_port_tx
//  Brief    : Bench for tri_port_tx; two instances (GAP=0, GAP=2) vs. a queue model.
//  Revision : 1.0
// ============================================================================
module tb_tri_port_tx;
    import tri_port_tx_pkg::*;

    localparam int DEPTH = 4;
    localparam int GAP_W = 4;
    localparam int GAP_A = 0;
    localparam int GAP_B = 2;
    localparam int NDUT  = 2;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NUM_PORTS-1:0] tx_en;
    logic                 clr_err;

    logic [7:0]           pd [NDUT][NUM_PORTS];
    logic                 pv [NDUT][NUM_PORTS];
    logic [2:0]           ff [NDUT];
    logic [2:0]           fe [NDUT];
    logic                 de [NDUT];

    tri_port_tx_if wr0 ();
    tri_port_tx_if wr1 ();

    always #5 clk = ~clk;

    tri_port_tx #(.DEPTH(DEPTH), .GAP(GAP_A), .GAP_W(GAP_W)) dut0 (
        .clk(clk), .rst_n(rst_n), .wr(wr0.slave), .tx_en(tx_en), .clr_err(clr_err),
        .port1_data(pd[0][0]), .port1_valid(pv[0][0]),
        .port2_data(pd[0][1]), .port2_valid(pv[0][1]),
        .port3_data(pd[0][2]), .port3_valid(pv[0][2]),
        .fifo_full(ff[0]), .fifo_empty(fe[0]), .drop_err(de[0])
    );

    tri_port_tx #(.DEPTH(DEPTH), .GAP(GAP_B), .GAP_W(GAP_W)) dut1 (
        .clk(clk), .rst_n(rst_n), .wr(wr1.slave), .tx_en(tx_en), .clr_err(clr_err),
        .port1_data(pd[1][0]), .port1_valid(pv[1][0]),
        .port2_data(pd[1][1]), .port2_valid(pv[1][1]),
        .port3_data(pd[1][2]), .port3_valid(pv[1][2]),
        .fifo_full(ff[1]), .fifo_empty(fe[1]), .drop_err(de[1])
    );

    // Reference model: per-port byte queues plus the cycle of each port's last beat.
    logic [7:0] mq     [NDUT][NUM_PORTS][DEPTH];
    int         mcnt   [NDUT][NUM_PORTS];
    int         mlast  [NDUT][NUM_PORTS];
    logic [7:0] mdata  [NDUT][NUM_PORTS];
    logic       mvalid [NDUT][NUM_PORTS];
    logic       mdrop  [NDUT];
    bit         m_acc  [NDUT];
    int         cyc;

    int nchecks = 0;
    int nerr    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_wr(input logic v, input logic [1:0] p, input logic [7:0] d);
        wr0.wr_valid = v; wr0.wr_port = p; wr0.wr_data = d;
        wr1.wr_valid = v; wr1.wr_port = p; wr1.wr_data = d;
    endtask

    function automatic bit m_ready(input int d);
        int pi;
        pi = int'(wr0.wr_port) - 1;
        if (pi < 0) return 1'b1;
        return mcnt[d][pi] < DEPTH;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < NDUT; d++) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                mcnt[d][p]   = 0;
                mlast[d][p]  = -1000;
                mdata[d][p]  = 8'h00;
                mvalid[d][p] = 1'b0;
            end
            mdrop[d] = 1'b0;
            m_acc[d] = 1'b0;
        end
    endtask

    // Beats on one port are at least GAP+1 cycles apart; everything uses pre-edge state.
    task automatic model_edge();
        int pi;
        int g;
        bit rdy;
        pi = int'(wr0.wr_port) - 1;
        for (int d = 0; d < NDUT; d++) begin
            g   = (d == 0) ? GAP_A : GAP_B;
            rdy = m_ready(d);
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (tx_en[p] && mcnt[d][p] > 0 && (cyc - mlast[d][p] > g)) begin
                    mdata[d][p] = mq[d][p][0];
                    for (int k = 0; k < DEPTH - 1; k++) mq[d][p][k] = mq[d][p][k+1];
                    mcnt[d][p]--;
                    mvalid[d][p] = 1'b1;
                    mlast[d][p]  = cyc;
                end else begin
                    mvalid[d][p] = 1'b0;
                end
            end
            m_acc[d] = wr0.wr_valid && rdy;
            if (m_acc[d] && pi >= 0) begin
                mq[d][pi][mcnt[d][pi]] = wr0.wr_data;
                mcnt[d][pi]++;
            end
            if (m_acc[d] && pi < 0) mdrop[d] = 1'b1;
            else if (clr_err)       mdrop[d] = 1'b0;
        end
        cyc++;
    endtask

    task automatic check_outputs();
        logic [2:0] ef;
        logic [2:0] ee;
        for (int d = 0; d < NDUT; d++) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                chk($sformatf("valid d%0d p%0d", d, p + 1), 32'(pv[d][p]), 32'(mvalid[d][p]));
                chk($sformatf("data d%0d p%0d", d, p + 1), 32'(pd[d][p]), 32'(mdata[d][p]));
                ef[p] = (mcnt[d][p] == DEPTH);
                ee[p] = (mcnt[d][p] == 0);
            end
            chk($sformatf("fifo_full d%0d", d), 32'(ff[d]), 32'(ef));
            chk($sformatf("fifo_empty d%0d", d), 32'(fe[d]), 32'(ee));
            chk($sformatf("drop_err d%0d", d), 32'(de[d]), 32'(mdrop[d]));
        end
    endtask

    task automatic cycle();
        #1;
        chk("wr_ready d0", 32'(wr0.wr_ready), 32'(m_ready(0)));
        chk("wr_ready d1", 32'(wr1.wr_ready), 32'(m_ready(1)));
        model_edge();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    logic [7:0] got [$];
    logic [6:0] pat;
    bit         accepted;

    initial begin
        rst_n = 1'b0;
        tx_en = 3'b000;
        clr_err = 1'b0;
        set_wr(1'b0, 2'd0, 8'h00);
        cyc = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;

        // Single byte to port 2, latency of two edges
        tx_en = 3'b111;
        set_wr(1'b1, 2'd2, 8'd5); cycle();
        set_wr(1'b0, 2'd0, 8'd0); cycle();
        chk("t1 p2 valid", 32'(pv[0][1]), 32'd1);
        chk("t1 p2 data", 32'(pd[0][1]), 32'd5);
        chk("t1 p1 valid", 32'(pv[0][0]), 32'd0);
        chk("t1 p3 valid", 32'(pv[0][2]), 32'd0);
        cycle();
        chk("t1 p2 one beat", 32'(pv[0][1]), 32'd0);

        // Fill port 1, refuse fifth, then drain in order
        tx_en = 3'b000;
        for (int i = 0; i < 4; i++) begin
            set_wr(1'b1, 2'd1, 8'(10 + i)); cycle();
        end
        set_wr(1'b1, 2'd1, 8'd14);
        #1;
        chk("t2 full", 32'(ff[0][0]), 32'd1);
        chk("t2 not empty", 32'(fe[0][0]), 32'd0);
        chk("t2 ready low", 32'(wr0.wr_ready), 32'd0);
        tx_en = 3'b001;
        got.delete();
        accepted = 1'b0;
        for (int i = 0; i < 10 && !accepted; i++) begin
            cycle();
            if (pv[0][0]) got.push_back(pd[0][0]);
            accepted = m_acc[0];
        end
        chk("t2 14 accepted", 32'(accepted), 32'd1);
        set_wr(1'b0, 2'd0, 8'd0);
        repeat (6) begin
            cycle();
            if (pv[0][0]) got.push_back(pd[0][0]);
        end
        chk("t2 beat count", 32'(got.size()), 32'd5);
        for (int i = 0; i < 5 && i < got.size(); i++) chk($sformatf("t2 order %0d", i), 32'(got[i]), 32'(10 + i));
        repeat (12) cycle();

        // GAP=2 instance: port 3 beat pattern
        tx_en = 3'b100;
        got.delete();
        set_wr(1'b1, 2'd3, 8'd1); cycle();
        set_wr(1'b1, 2'd3, 8'd2); cycle();
        pat[6] = pv[1][2]; if (pv[1][2]) got.push_back(pd[1][2]);
        set_wr(1'b1, 2'd3, 8'd3); cycle();
        pat[5] = pv[1][2]; if (pv[1][2]) got.push_back(pd[1][2]);
        set_wr(1'b0, 2'd0, 8'd0);
        for (int k = 0; k < 5; k++) begin
            cycle();
            pat[4-k] = pv[1][2];
            if (pv[1][2]) got.push_back(pd[1][2]);
        end
        chk("t3 gap pattern", 32'(pat), 32'b1001001);
        chk("t3 beat count", 32'(got.size()), 32'd3);
        for (int i = 0; i < 3 && i < got.size(); i++) chk($sformatf("t3 data %0d", i), 32'(got[i]), 32'(i + 1));

        // Three ports released together
        tx_en = 3'b000;
        set_wr(1'b1, 2'd1, 8'hAA); cycle();
        set_wr(1'b1, 2'd2, 8'hBB); cycle();
        set_wr(1'b1, 2'd3, 8'hCC); cycle();
        set_wr(1'b0, 2'd0, 8'h00); cycle();
        tx_en = 3'b111;
        cycle();
        chk("t4 p1 valid", 32'(pv[0][0]), 32'd1);
        chk("t4 p2 valid", 32'(pv[0][1]), 32'd1);
        chk("t4 p3 valid", 32'(pv[0][2]), 32'd1);
        chk("t4 p1 data", 32'(pd[0][0]), 32'hAA);
        chk("t4 p2 data", 32'(pd[0][1]), 32'hBB);
        chk("t4 p3 data", 32'(pd[0][2]), 32'hCC);
        repeat (4) cycle();

        // Illegal destination and drop_err clearing
        tx_en = 3'b000;
        set_wr(1'b1, 2'd0, 8'h7F);
        #1;
        chk("t5 ready illegal", 32'(wr0.wr_ready), 32'd1);
        cycle();
        chk("t5 drop set", 32'(de[0]), 32'd1);
        clr_err = 1'b1;
        cycle();
        chk("t5 set wins", 32'(de[0]), 32'd1);
        set_wr(1'b0, 2'd0, 8'h00);
        cycle();
        chk("t5 cleared", 32'(de[0]), 32'd0);
        clr_err = 1'b0;

        // Reset mid-stream
        for (int i = 0; i < 4; i++) begin
            set_wr(1'b1, 2'd1, 8'(8'h40 + i)); cycle();
        end
        set_wr(1'b0, 2'd0, 8'h00);
        tx_en = 3'b001;
        cycle();
        chk("t6 valid before rst", 32'(pv[0][0]), 32'd1);
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < NDUT; d++) begin
            for (int p = 0; p < NUM_PORTS; p++) chk($sformatf("t6 rst valid d%0d p%0d", d, p + 1), 32'(pv[d][p]), 32'd0);
            chk($sformatf("t6 rst empty d%0d", d), 32'(fe[d]), 32'b111);
        end
        model_reset();
        tx_en = 3'b111;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) begin
            cycle();
            chk("t6 silent p1", 32'(pv[0][0]), 32'd0);
        end

        // Randomised traffic
        for (int i = 0; i < 500; i++) begin
            set_wr(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom));
            tx_en   = 3'($urandom);
            clr_err = ($urandom_range(0, 7) == 0);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end
endmodule
`default_nettype wire
